// File: rtl/mem_burst_sched.sv
// Two-requester main-memory port scheduler: ring and aux ports share one
// 32-bit memory array, each request served as an 8-word line burst with round-robin arbitration.
module mem_burst_sched #(
  parameter int MBITS = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  // ring requester
  input  logic                 ring_req,
  input  logic                 ring_wr,
  input  logic [MBITS-4:0]     ring_line,
  input  logic [3:0]           ring_dest,
  output logic                 ring_ack,
  input  logic [31:0]          ring_wdata,
  input  logic                 ring_wdata_empty,
  output logic                 ring_wdata_rd,
  // aux requester
  input  logic                 aux_req,
  input  logic                 aux_wr,
  input  logic [MBITS-4:0]     aux_line,
  output logic                 aux_ack,
  input  logic [31:0]          aux_wdata,
  input  logic                 aux_wdata_valid,
  output logic                 aux_wdata_rd,
  output logic [31:0]          aux_rdata,
  output logic                 aux_rvalid,
  // memory array
  output logic [MBITS-1:0]     mem_addr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  // ring read return bus
  output logic [31:0]          rd_return,
  output logic [3:0]           rd_dest,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nx;
  logic [2:0]        beat, beat_nx;
  logic [MBITS-4:0]  line, line_nx;
  logic [3:0]        dest, dest_nx;
  logic              owner_aux, owner_aux_nx;
  logic              last_aux, last_aux_nx;

  logic ring_elig, aux_elig, grant_ring, grant_aux, wr_avail;
  logic ring_rd_beat, aux_rd_beat;

  // A write only competes once its first data word is already waiting.
  assign ring_elig  = ring_req & (~ring_wr | ~ring_wdata_empty);
  assign aux_elig   = aux_req  & (~aux_wr  | aux_wdata_valid);
  assign grant_ring = ring_elig & (~aux_elig | last_aux);
  assign grant_aux  = aux_elig & ~grant_ring;

  assign wr_avail     = owner_aux ? aux_wdata_valid : ~ring_wdata_empty;
  assign ring_rd_beat = (state == READ) & ~owner_aux;
  assign aux_rd_beat  = (state == READ) &  owner_aux;

  assign mem_addr  = {line, beat};
  assign mem_wdata = owner_aux ? aux_wdata : ring_wdata;
  assign busy      = (state != IDLE);

  // NOTE: every output and next-state value gets a default first so no latch is inferred.
  always_comb begin
    state_nx      = state;
    beat_nx       = beat;
    line_nx       = line;
    dest_nx       = dest;
    owner_aux_nx  = owner_aux;
    last_aux_nx   = last_aux;
    ring_ack      = 1'b0;
    aux_ack       = 1'b0;
    mem_we        = 1'b0;
    ring_wdata_rd = 1'b0;
    aux_wdata_rd  = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_ring || grant_aux) begin
          ring_ack     = grant_ring;
          aux_ack      = grant_aux;
          owner_aux_nx = grant_aux;
          last_aux_nx  = grant_aux;
          line_nx      = grant_aux ? aux_line : ring_line;
          dest_nx      = grant_aux ? 4'd0 : ring_dest;
          beat_nx      = 3'd0;
          state_nx     = (grant_aux ? aux_wr : ring_wr) ? WRITE : READ;
        end
      end
      READ: begin
        beat_nx = beat + 3'd1;
        if (beat == 3'd7) state_nx = IDLE;
      end
      WRITE: begin
        // Missing data stalls the burst in place; the beat counter holds.
        if (wr_avail) begin
          mem_we        = 1'b1;
          ring_wdata_rd = ~owner_aux;
          aux_wdata_rd  = owner_aux;
          beat_nx       = beat + 3'd1;
          if (beat == 3'd7) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= 3'd0;
      line       <= '0;
      dest       <= 4'd0;
      owner_aux  <= 1'b0;
      last_aux   <= 1'b1;
      rd_return  <= 32'd0;
      rd_dest    <= 4'd0;
      aux_rdata  <= 32'd0;
      aux_rvalid <= 1'b0;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      line       <= line_nx;
      dest       <= dest_nx;
      owner_aux  <= owner_aux_nx;
      last_aux   <= last_aux_nx;
      rd_return  <= ring_rd_beat ? mem_rdata : 32'd0;
      rd_dest    <= ring_rd_beat ? dest : 4'd0;
      aux_rdata  <= aux_rd_beat ? mem_rdata : 32'd0;
      aux_rvalid <= aux_rd_beat;
    end
  end

endmodule

// File: tb/tb_mem_burst_sched.sv
// Self-checking bench for mem_burst_sched: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_burst_sched;

  localparam int MB = 10;
  localparam int LB = MB - 3;

  logic          clock, reset;
  logic          ring_req, ring_wr, ring_ack, ring_wdata_empty, ring_wdata_rd;
  logic [LB-1:0] ring_line;
  logic [3:0]    ring_dest;
  logic [31:0]   ring_wdata;
  logic          aux_req, aux_wr, aux_ack, aux_wdata_valid, aux_wdata_rd, aux_rvalid;
  logic [LB-1:0] aux_line;
  logic [31:0]   aux_wdata, aux_rdata;
  logic [MB-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata, rd_return;
  logic [3:0]    rd_dest;
  logic          busy;

  mem_burst_sched #(.MBITS(MB)) dut (
    .clock(clock), .reset(reset),
    .ring_req(ring_req), .ring_wr(ring_wr), .ring_line(ring_line), .ring_dest(ring_dest),
    .ring_ack(ring_ack), .ring_wdata(ring_wdata), .ring_wdata_empty(ring_wdata_empty),
    .ring_wdata_rd(ring_wdata_rd),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_line(aux_line), .aux_ack(aux_ack),
    .aux_wdata(aux_wdata), .aux_wdata_valid(aux_wdata_valid), .aux_wdata_rd(aux_wdata_rd),
    .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_return(rd_return), .rd_dest(rd_dest), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory array seen by the DUT and the model's private copy of it.
  logic [31:0] mem     [0:(1<<MB)-1];
  logic [31:0] ref_mem [0:(1<<MB)-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_busy, m_aux, m_wr, m_last_aux;
  logic [LB-1:0] m_line;
  logic [3:0]  m_dest;
  int          m_done, m_addr;
  bit          r_ok, a_ok, avail;
  bit          e_rack, e_aack, e_we, e_rpop, e_apop;
  logic [31:0] wd;
  logic [31:0] nx_rdr, cur_rdr, nx_ad, cur_ad;
  logic [3:0]  nx_rdd, cur_rdd;
  bit          nx_av, cur_av;

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 0; m_last_aux = 1; m_done = 0;
      nx_rdr = 0; nx_rdd = 0; nx_ad = 0; nx_av = 0;
    end else begin
      cur_rdr = nx_rdr; cur_rdd = nx_rdd; cur_ad = nx_ad; cur_av = nx_av;
      nx_rdr = 0; nx_rdd = 0; nx_ad = 0; nx_av = 0;
      e_rack = 0; e_aack = 0; e_we = 0; e_rpop = 0; e_apop = 0;
      if (!m_busy) begin
        check("m_busy_idle", busy, 0);
        r_ok = ring_req && (!ring_wr || !ring_wdata_empty);
        a_ok = aux_req && (!aux_wr || aux_wdata_valid);
        if (r_ok && (!a_ok || m_last_aux)) begin
          e_rack = 1; m_busy = 1; m_aux = 0; m_wr = ring_wr;
          m_line = ring_line; m_dest = ring_dest; m_done = 0; m_last_aux = 0;
        end else if (a_ok) begin
          e_aack = 1; m_busy = 1; m_aux = 1; m_wr = aux_wr;
          m_line = aux_line; m_dest = 0; m_done = 0; m_last_aux = 1;
        end
      end else begin
        m_addr = m_line * 8 + m_done;
        check("m_busy_burst", busy, 1);
        check("m_mem_addr", mem_addr, m_addr);
        if (!m_wr) begin
          if (m_aux) begin nx_av = 1; nx_ad = ref_mem[m_addr]; end
          else begin nx_rdd = m_dest; nx_rdr = ref_mem[m_addr]; end
          m_done++;
        end else begin
          avail = m_aux ? aux_wdata_valid : !ring_wdata_empty;
          if (avail) begin
            wd = m_aux ? aux_wdata : ring_wdata;
            e_we = 1; e_apop = m_aux; e_rpop = !m_aux;
            ref_mem[m_addr] = wd;
            check("m_mem_wdata", mem_wdata, wd);
            m_done++;
          end
        end
        if (m_done == 8) m_busy = 0;
      end
      check("m_ring_ack", ring_ack, e_rack);
      check("m_aux_ack", aux_ack, e_aack);
      check("m_mem_we", mem_we, e_we);
      check("m_ring_pop", ring_wdata_rd, e_rpop);
      check("m_aux_pop", aux_wdata_rd, e_apop);
      check("m_rd_return", rd_return, cur_rdr);
      check("m_rd_dest", rd_dest, cur_rdd);
      check("m_aux_rdata", aux_rdata, cur_ad);
      check("m_aux_rvalid", aux_rvalid, cur_av);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clock);
    while (busy && n < budget) begin
      tick();
      @(negedge clock);
      n++;
    end
    check("idle_reached", busy, 0);
    tick();
  endtask

  task automatic ring_read_line5(input string tag);
    ring_req = 1; ring_wr = 0; ring_line = 5; ring_dest = 3;
    @(negedge clock);
    check({tag, "_ack_T"}, ring_ack, 1);
    tick();
    ring_req = 0;
    @(negedge clock);
    check({tag, "_ack_T1"}, ring_ack, 0);
    check({tag, "_dest_T1"}, rd_dest, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clock);
      check({tag, "_rdata"}, rd_return, 32'h500 + k);
      check({tag, "_rdest"}, rd_dest, 3);
    end
    tick();
    @(negedge clock);
    check({tag, "_dest_T10"}, rd_dest, 0);
    check({tag, "_ret_T10"}, rd_return, 0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pops, we_cnt, busy_cnt, st, stall_seen;
    bit acked;
    int g_who [4];
    int g_cyc [4];
    int n_g;

    for (int i = 0; i < (1 << MB); i++) begin
      mem[i] = 32'h0C00_0000 + i;
      ref_mem[i] = 32'h0C00_0000 + i;
    end
    for (int k = 0; k < 8; k++) begin
      mem[40 + k] = 32'h500 + k;
      ref_mem[40 + k] = 32'h500 + k;
    end

    reset = 1;
    ring_req = 0; ring_wr = 0; ring_line = 0; ring_dest = 0;
    ring_wdata = 0; ring_wdata_empty = 1;
    aux_req = 0; aux_wr = 0; aux_line = 0; aux_wdata = 0; aux_wdata_valid = 0;
    tick();
    tick();
    reset = 0;

    // Reset state
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_rd_dest", rd_dest, 0);
    check("rst_rd_return", rd_return, 0);
    check("rst_aux_rvalid", aux_rvalid, 0);
    check("rst_mem_addr", mem_addr, 0);
    tick();

    // Ring read of line 5
    ring_read_line5("rr");

    // Aux write line 9 with a two-cycle data stall after beat 3
    aux_req = 1; aux_wr = 1; aux_line = 9; aux_wdata_valid = 1; aux_wdata = 32'hA0;
    pops = 0; we_cnt = 0; busy_cnt = 0; st = 0; stall_seen = 0; acked = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c == 0) check("aw_ack", aux_ack, 1);
      if (aux_ack) acked = 1;
      if (mem_we) we_cnt++;
      if (busy) busy_cnt++;
      if (busy && !aux_wdata_valid) begin
        stall_seen++;
        check("aw_no_we_in_stall", mem_we, 0);
      end
      if (aux_wdata_rd) pops++;
      tick();
      if (acked) aux_req = 0;
      aux_wdata = 32'hA0 + pops;
      if (pops == 4 && st < 2) begin
        aux_wdata_valid = 0;
        st++;
      end else begin
        aux_wdata_valid = (pops < 8);
      end
    end
    aux_wr = 0;
    check("aw_we_count", we_cnt, 8);
    check("aw_busy_cycles", busy_cnt, 10);
    check("aw_stall_cycles", stall_seen, 2);
    for (int k = 0; k < 8; k++) check("aw_mem", mem[72 + k], 32'hA0 + k);
    wait_idle(20);

    // Ring write without data while an aux read is pending
    ring_req = 1; ring_wr = 1; ring_line = 3; ring_wdata_empty = 1; ring_wdata = 32'hB0;
    aux_req = 1; aux_wr = 0; aux_line = 4;
    @(negedge clock);
    check("iw_aux_first", aux_ack, 1);
    check("iw_ring_wait", ring_ack, 0);
    tick();
    aux_req = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      check("iw_ring_held", ring_ack, 0);
      tick();
    end
    ring_wdata_empty = 0;
    pops = 0; acked = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c == 0) check("iw_ring_grant", ring_ack, 1);
      if (ring_ack) acked = 1;
      if (ring_wdata_rd) pops++;
      tick();
      if (acked) ring_req = 0;
      ring_wdata = 32'hB0 + pops;
      ring_wdata_empty = (pops >= 8);
    end
    ring_wr = 0;
    check("iw_pops", pops, 8);
    for (int k = 0; k < 8; k++) check("iw_mem", mem[24 + k], 32'hB0 + k);
    wait_idle(20);

    // Reset in the middle of a ring read (during beat 4)
    ring_req = 1; ring_wr = 0; ring_line = 5; ring_dest = 3;
    @(negedge clock);
    check("rm_ack", ring_ack, 1);
    tick();
    ring_req = 0;
    for (int c = 0; c < 4; c++) tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clock);
    check("rm_busy", busy, 0);
    check("rm_rd_dest", rd_dest, 0);
    check("rm_rd_return", rd_return, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clock);
      check("rm_quiet_dest", rd_dest, 0);
    end
    tick();
    ring_read_line5("rm_after");

    // Contention: both read continuously from reset
    reset = 1;
    ring_req = 1; ring_wr = 0; ring_line = 1; ring_dest = 2;
    aux_req = 1; aux_wr = 0; aux_line = 2;
    tick();
    reset = 0;
    n_g = 0;
    for (int i = 0; i < 4; i++) begin g_who[i] = -1; g_cyc[i] = -1; end
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      check("ct_not_both", ring_ack & aux_ack, 0);
      if ((ring_ack || aux_ack) && n_g < 4) begin
        g_who[n_g] = aux_ack ? 1 : 0;
        g_cyc[n_g] = c;
        n_g++;
      end
      tick();
      if (n_g == 4) begin ring_req = 0; aux_req = 0; end
    end
    check("ct_n_grants", n_g, 4);
    check("ct_g0_ring", g_who[0], 0);
    check("ct_g1_aux", g_who[1], 1);
    check("ct_g2_ring", g_who[2], 0);
    check("ct_g3_aux", g_who[3], 1);
    check("ct_g0_cycle", g_cyc[0], 0);
    for (int i = 1; i < 4; i++) check("ct_spacing", g_cyc[i] - g_cyc[i-1], 9);
    wait_idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
